// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
// Contents:
//   tx_state_t       - transmit engine states
//   calc_bit_period  - clk cycles per serial bit, clamped to at least 1
//   even_parity      - even-parity bit of a byte
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  function automatic int calc_bit_period(input int clk_freq, input int bit_rate);
    int p;
    p = clk_freq / bit_rate;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO used as the UART transmit buffer.
// Ports:
//   clk, rst            - clock, async active-high reset
//   push, push_data     - write request/data (ignored when full)
//   pop, pop_data       - read request (ignored when empty); pop_data shows head entry
//   full, empty, level  - occupancy status (level is DEPTH-inclusive)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  // Decisions use pre-edge status: a push at full is dropped even if a pop
  // frees a slot on the same edge.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes pushed into a FIFO are serialised on tx,
// LSB first, with a start bit, optional even parity and one stop bit.
// Build option: define UART_TX_PARITY_EN for 8E1 frames; otherwise 8N1.
// Ports:
//   clk, rst         - clock, async active-high reset
//   wr_en, wr_data   - byte push request
//   full, empty      - FIFO status
//   level            - FIFO occupancy
//   overflow         - one-cycle pulse when a push is dropped at full
//   tx               - serial output, idles high
//   busy             - frame in flight or bytes pending
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BIT_RATE   = 115200,
  parameter int CLK_FREQ   = 500_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy
);
  localparam int BIT_PERIOD = calc_bit_period(CLK_FREQ, BIT_RATE);
  localparam int CW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_PERIOD - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    fifo_dout;
  logic          pop;
  logic          baud_tick;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  // The engine is the only consumer; it pulls the next byte from IDLE.
  assign pop       = (state == IDLE) & ~empty;
  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE) | ~empty;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= wr_en & full;
  end

  // tx is registered one bit ahead: each transition drives the level for the
  // state being entered, so the start bit appears right after the pop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (state == IDLE) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      if (!empty) begin
        shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
        par   <= even_parity(fifo_dout);
`endif
        state <= START;
        tx    <= 1'b0;
      end
    end else if (baud_tick) begin
      baud_cnt <= '0;
      case (state)
        START: begin
          state   <= DATA;
          tx      <= shift[0];
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            shift   <= shift >> 1;
            tx      <= shift[1];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        default: begin
          // STOP, and recovery from any unused encoding
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered UART transmitter, the transmit-side complement to the existing UART receive path. The CPU/bus side pushes bytes into an internal FIFO. A bit-timing engine serialises each byte onto `tx`, LSB first, with start bit, optional even parity and one stop bit. The frame format matches the receiver's expected format, so the two can be looped back on `tx`/`rx`.

Parameters:
- BIT_RATE, 115200, serial bit rate in bits/s.
- CLK_FREQ, 500_000, clk frequency in Hz. BIT_PERIOD = CLK_FREQ/BIT_RATE (integer division, clamped to a minimum of 1); default is 4 cycles.
- FIFO_DEPTH, 8, number of byte entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request; sampled on the rising edge of clk.
- wr_data  in  8  byte to push.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  one-cycle pulse when a push is dropped.
- tx  out  1  serial output; idles high.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.

Behaviour:
- Reset (async, while rst=1):
  - Outputs: tx=1, busy=0, full=0, empty=1, level=0, overflow=0.
  - FIFO pointers cleared; engine to IDLE; bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame immediately (tx high in the same instant); no partial frame resumes.
- Push:
  - wr_en=1 and full=0 at a clock edge: wr_data is stored and level increments.
  - wr_en=1 and full=1: the byte is dropped, overflow=1 for exactly one cycle, and FIFO contents are unchanged.
  - `full` uses the pre-edge level. A push at full is rejected even if a pop occurs on the same edge.
- Pop: performed only by the engine, in IDLE, when empty=0. A push and a pop on the same edge (level not 0, not full) leave level unchanged.
- Pointers: $clog2(FIFO_DEPTH) bits each, natural wrap-around. level = write count minus read count.
- Engine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If !empty, pop into the shift register, compute parity, and go to START; tx is registered low on that same edge.
  - START: tx=0 for BIT_PERIOD cycles, then DATA.
  - DATA: tx = shift[0] for BIT_PERIOD cycles per bit, shifting right after each bit. After 8 bits, go to PARITY (if enabled) or STOP.
  - PARITY: tx = ^byte (even parity) for BIT_PERIOD cycles, then STOP.
  - STOP: tx=1 for BIT_PERIOD cycles, then IDLE.
- Baud counter: counts 0..BIT_PERIOD-1, restarts on every state entry, and advances the state/bit on terminal count.
- Latency:
  - Byte pushed at edge N into an empty FIFO with the engine idle: the pop occurs at edge N+1, and tx falls after edge N+1.
  - Back-to-back frames: after STOP, IDLE lasts exactly one cycle (tx=1) before the next start bit.
- Frame length: 11 x BIT_PERIOD cycles with parity, 10 x BIT_PERIOD without.
- busy = (state != IDLE) | !empty. It deasserts the cycle after the last STOP cycle when the FIFO is empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state exists and the even-parity bit is inserted after bit 7. This is the 8E1 format, matching the receiver's parity check.
- Undefined: the PARITY state and parity logic are compiled out; DATA goes directly to STOP (8N1).

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - localparam function for BIT_PERIOD with clamp.
  - even_parity(byte) function, shared with the receive path.
- One sub-module, uart_sync_fifo: parameterised width/depth, push/pop, full/empty/level, async active-high rst.
- Engine and overflow logic live in uart_tx_buffered.

Test Plan:
- Reset then idle 100 cycles: tx=1, busy=0, empty=1, level=0 throughout.
- Push 0xA5 (with UART_TX_PARITY_EN):
  - tx low one cycle after the pop.
  - Sampled mid-bit every 4 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - busy falls 44 cycles after the start bit.
- Push 0x3C, 0xFF, 0x00 on consecutive cycles:
  - level peaks at 2.
  - Three frames with exactly one idle cycle between them; parity bits 0, 0, 0.
  - Loopback into UART rx gives rx_valid three times with data 0x3C, 0xFF, 0x00 and parity_error=0.
- Push 9 bytes 0x01..0x09 while the engine is busy on a prior frame:
  - full=1 at level 8.
  - The 9th push gives a single-cycle overflow pulse, and 0x09 is never transmitted.
- Assert rst for 1 cycle in the middle of DATA of 0x55:
  - tx=1 immediately, FIFO emptied.
  - A subsequent push of 0x81 transmits cleanly.
- Build without UART_TX_PARITY_EN, push 0x80: frame is 40 cycles, stop bit directly follows bit 7.
